// File: rtl/io_arb_pkg.sv
// Shared types and default constants for the two-requester pad-group arbiter.
// Consumed by io_bus_arbiter and its testbench.
package io_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        OWN  = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_IO      = 32;
    localparam int DEF_TURN_CYCLES = 2;
    localparam int DEF_MAX_HOLD    = 255;

endpackage

// File: rtl/io_arb_rr2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one
// that was not granted last.
module io_arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       pick
);

    always_comb begin
        pick = 1'b0;
        case (req)
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last;
            default: pick = 1'b0;
        endcase
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Arbitrates a shared bidirectional pad group between two requesters with a
// tri-stated turnaround before every grant. Define IO_ARB_TIMEOUT_EN to add
// a MAX_HOLD ownership limit that preempts an owner when the other requests.
module io_bus_arbiter
    import io_arb_pkg::*;
#(
    parameter int NUM_IO      = DEF_NUM_IO,
    parameter int TURN_CYCLES = DEF_TURN_CYCLES,
    parameter int MAX_HOLD    = DEF_MAX_HOLD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    output logic [1:0]        gnt,
    input  logic [NUM_IO-1:0] r0_out,
    input  logic [NUM_IO-1:0] r1_out,
    input  logic [NUM_IO-1:0] r0_oeb,
    input  logic [NUM_IO-1:0] r1_oeb,
    input  logic [NUM_IO-1:0] io_in,
    output logic [NUM_IO-1:0] io_out,
    output logic [NUM_IO-1:0] io_oeb,
    output logic [NUM_IO-1:0] rd_in,
    output logic              busy
);

    if (TURN_CYCLES < 1 || TURN_CYCLES > 15 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_param
        $error("io_bus_arbiter: TURN_CYCLES or MAX_HOLD out of range");
    end

    arb_state_e        state_q, state_d;
    logic              winner_q, winner_d;
    logic              last_q, last_d;
    logic [3:0]        turn_cnt_q, turn_cnt_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [NUM_IO-1:0] io_out_q, io_out_d;
    logic [NUM_IO-1:0] io_oeb_q, io_oeb_d;
    logic [NUM_IO-1:0] rd_in_q, rd_in_d;
    logic              pick;

`ifdef IO_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
    logic [7:0] hold_cnt_q, hold_cnt_d;
`endif

    io_arb_rr2 u_rr2 (
        .req  (req),
        .last (last_q),
        .pick (pick)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        winner_d   = winner_q;
        last_d     = last_q;
        turn_cnt_d = turn_cnt_q;
        gnt_d      = 2'b00;
        io_out_d   = '0;
        io_oeb_d   = '1;
        rd_in_d    = io_in;
`ifdef IO_ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = TURN;
                    winner_d   = pick;
                    turn_cnt_d = 4'(TURN_CYCLES - 1);
                end
            end
            TURN: begin
                // An abandoned request aborts quietly; the pointer only moves on a real grant.
                if (!req[winner_q]) begin
                    state_d = IDLE;
                end else if (turn_cnt_q == 4'd0) begin
                    state_d         = OWN;
                    gnt_d[winner_q] = 1'b1;
                    last_d          = winner_q;
`ifdef IO_ARB_TIMEOUT_EN
                    hold_cnt_d      = 8'd1;
`endif
                end else begin
                    turn_cnt_d = turn_cnt_q - 4'd1;
                end
            end
            OWN: begin
                if (!req[winner_q]) begin
                    state_d = IDLE;
`ifdef IO_ARB_TIMEOUT_EN
                end else if (hold_cnt_q == HOLD_LIMIT && req[!winner_q]) begin
                    state_d = IDLE;
`endif
                end else begin
                    // Pads copy only the owner, and only once it has seen its grant.
                    gnt_d[winner_q] = 1'b1;
                    io_out_d        = winner_q ? r1_out : r0_out;
                    io_oeb_d        = winner_q ? r1_oeb : r0_oeb;
`ifdef IO_ARB_TIMEOUT_EN
                    if (hold_cnt_q != HOLD_LIMIT) hold_cnt_d = hold_cnt_q + 8'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments; the async reset drives pads to release without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            winner_q   <= 1'b0;
            last_q     <= 1'b1;
            turn_cnt_q <= 4'd0;
            gnt_q      <= 2'b00;
            io_out_q   <= '0;
            io_oeb_q   <= '1;
            rd_in_q    <= '0;
`ifdef IO_ARB_TIMEOUT_EN
            hold_cnt_q <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            winner_q   <= winner_d;
            last_q     <= last_d;
            turn_cnt_q <= turn_cnt_d;
            gnt_q      <= gnt_d;
            io_out_q   <= io_out_d;
            io_oeb_q   <= io_oeb_d;
            rd_in_q    <= rd_in_d;
`ifdef IO_ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    assign gnt    = gnt_q;
    assign io_out = io_out_q;
    assign io_oeb = io_oeb_q;
    assign rd_in  = rd_in_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Randomised bench for io_bus_arbiter against a cycle-level protocol model;
// IO_ARB_TIMEOUT_EN switches the model and DUT to a MAX_HOLD of 4.
module tb_io_bus_arbiter;

    localparam int NUM_IO = 32;
    localparam int TURN   = 2;
`ifdef IO_ARB_TIMEOUT_EN
    localparam int TB_MAX_HOLD = 4;
`else
    localparam int TB_MAX_HOLD = 255;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic [NUM_IO-1:0] r0_out, r1_out, r0_oeb, r1_oeb, io_in;
    logic [NUM_IO-1:0] io_out, io_oeb, rd_in;
    logic              busy;

    io_bus_arbiter #(
        .NUM_IO      (NUM_IO),
        .TURN_CYCLES (TURN),
        .MAX_HOLD    (TB_MAX_HOLD)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .gnt    (gnt),
        .r0_out (r0_out),
        .r1_out (r1_out),
        .r0_oeb (r0_oeb),
        .r1_oeb (r1_oeb),
        .io_in  (io_in),
        .io_out (io_out),
        .io_oeb (io_oeb),
        .rd_in  (rd_in),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Protocol model: owner index (-1 none), remaining turnaround cycles, last grantee.
    int          m_own, m_left, m_cand, m_last, m_hold;
    logic [1:0]  a_req;
    logic [31:0] a_out [2];
    logic [31:0] a_oeb [2];
    logic [31:0] a_in;
    logic [1:0]  exp_gnt;
    logic        exp_busy;
    logic [31:0] exp_out, exp_oeb, exp_rd;

    task automatic model_reset();
        m_own    = -1;
        m_left   = 0;
        m_cand   = 0;
        m_last   = 1;
        m_hold   = 0;
        exp_gnt  = 2'b00;
        exp_busy = 1'b0;
        exp_out  = '0;
        exp_oeb  = '1;
        exp_rd   = '0;
    endtask

    task automatic model_step();
        exp_rd  = a_in;
        exp_out = '0;
        exp_oeb = '1;
        if (m_own >= 0) begin
            if (!a_req[m_own]) begin
                m_own = -1;
`ifdef IO_ARB_TIMEOUT_EN
            end else if (m_hold == TB_MAX_HOLD && a_req[1 - m_own]) begin
                m_own = -1;
`endif
            end else begin
                exp_out = a_out[m_own];
                exp_oeb = a_oeb[m_own];
                if (m_hold < TB_MAX_HOLD) m_hold++;
            end
        end else if (m_left > 0) begin
            if (!a_req[m_cand]) begin
                m_left = 0;
            end else if (m_left == 1) begin
                m_left = 0;
                m_own  = m_cand;
                m_last = m_cand;
                m_hold = 1;
            end else begin
                m_left--;
            end
        end else if (a_req != 2'b00) begin
            if (a_req == 2'b11) m_cand = 1 - m_last;
            else                m_cand = a_req[1] ? 1 : 0;
            m_left = TURN;
        end
        exp_gnt  = (m_own < 0) ? 2'b00 : (m_own == 0 ? 2'b01 : 2'b10);
        exp_busy = (m_own >= 0) || (m_left > 0);
    endtask

    // One clock: capture inputs, advance the model at the edge, compare just after it.
    task automatic cycle();
        a_req    = req;
        a_out[0] = r0_out;
        a_out[1] = r1_out;
        a_oeb[0] = r0_oeb;
        a_oeb[1] = r1_oeb;
        a_in     = io_in;
        @(posedge clk);
        model_step();
        #1;
        check("gnt", {30'b0, gnt}, {30'b0, exp_gnt});
        check("gnt_onehot", {31'b0, gnt[0] & gnt[1]}, 32'd0);
        check("busy", {31'b0, busy}, {31'b0, exp_busy});
        check("io_out", io_out, exp_out);
        check("io_oeb", io_oeb, exp_oeb);
        check("rd_in", rd_in, exp_rd);
        io_in = $urandom;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", {30'b0, gnt}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_io_out", io_out, 32'd0);
        check("rst_io_oeb", io_oeb, 32'hFFFF_FFFF);
        check("rst_rd_in", rd_in, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = 2'b00;
        r0_out = '0;
        r1_out = '0;
        r0_oeb = '1;
        r1_oeb = '1;
        io_in  = '0;
        apply_reset();

        // Single request from reset: busy next cycle, grant after the turnaround.
        req = 2'b01;
        cycle();
        check("c1_busy", {31'b0, busy}, 32'd1);
        check("c1_gnt", {30'b0, gnt}, 32'd0);
        cycle();
        check("c2_io_oeb", io_oeb, 32'hFFFF_FFFF);
        cycle();
        check("c3_gnt", {30'b0, gnt}, 32'd1);

        // Owner drives, non-owner noise must never reach the pads.
        r0_out = 32'hA5A5_A5A5;
        r0_oeb = '0;
        r1_out = 32'h5A5A_5A5A;
        r1_oeb = 32'h0F0F_0F0F;
        cycle();
        check("own_io_out", io_out, 32'hA5A5_A5A5);
        check("own_io_oeb", io_oeb, 32'd0);

        // Reset mid-ownership releases the pads before any clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_io_oeb", io_oeb, 32'hFFFF_FFFF);
        check("async_gnt", {30'b0, gnt}, 32'd0);
        apply_reset();

        // Request abandoned during turnaround: no grant, pointer untouched.
        req = 2'b10;
        cycle();
        req = 2'b00;
        cycle();
        check("abort_busy", {31'b0, busy}, 32'd0);
        cycle();
        req = 2'b01;
        repeat (3) cycle();
        check("abort_then_r0", {30'b0, gnt}, 32'd1);
        req = 2'b00;
        cycle();
        apply_reset();

        // Both requesting: owners alternate with a three-cycle tri-stated gap.
        req = 2'b11;
        repeat (3) cycle();
        check("rr_first", {30'b0, gnt}, 32'd1);
        repeat (2) cycle();
        req = 2'b10;
        cycle();
        check("rr_release0", {30'b0, gnt}, 32'd0);
        req = 2'b11;
        repeat (2) cycle();
        check("rr_gap_oeb", io_oeb, 32'hFFFF_FFFF);
        cycle();
        check("rr_second", {30'b0, gnt}, 32'd2);
        req = 2'b01;
        cycle();
        req = 2'b11;
        repeat (3) cycle();
        check("rr_third", {30'b0, gnt}, 32'd1);

`ifdef IO_ARB_TIMEOUT_EN
        // Both held: each tenure is capped and ownership alternates.
        repeat (40) cycle();
`endif

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 2) == 0) req[i] = 1'b1;
                end else if (m_own == i) begin
                    if ($urandom_range(0, 5) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 19) == 0) begin
                    req[i] = 1'b0;
                end
            end
            r0_out = $urandom;
            r1_out = $urandom;
            r0_oeb = ($urandom_range(0, 1) == 0) ? '0 : NUM_IO'($urandom);
            r1_oeb = ($urandom_range(0, 1) == 0) ? '0 : NUM_IO'($urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
